// File: rtl/comparator_bist.sv
// Built-in self-test for a WIDTH-bit magnitude comparator.
// Sweeps every (a, b) operand pair with b as the inner loop, waits SETTLE cycles per pair,
// then checks the {eq, gt, lt} flags against an unsigned reference compare. It counts the
// failing pairs and captures the first one.
module comparator_bist #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   input  logic               eq_in,
   input  logic               gt_in,
   input  logic               lt_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b
);

   localparam int unsigned ErrW       = 2 * WIDTH + 1;
   localparam logic [3:0]  SettleInit = 4'(SETTLE);

   typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

   state_e           state_q, state_d;
   logic [3:0]       settle_q, settle_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [ErrW-1:0]  err_q, err_d;
   logic [WIDTH-1:0] fail_a_q, fail_a_d;
   logic [WIDTH-1:0] fail_b_q, fail_b_d;

   logic [2:0]       exp_flags;
   logic             pair_fail;

   // Reference compare; any flag pattern other than the exact one-hot answer is a failure.
   always_comb begin
      exp_flags = {a_q == b_q, a_q > b_q, a_q < b_q};
      pair_fail = ({eq_in, gt_in, lt_in} != exp_flags);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         settle_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         err_q    <= '0;
         fail_a_q <= '0;
         fail_b_q <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         a_q      <= a_d;
         b_q      <= b_d;
         err_q    <= err_d;
         fail_a_q <= fail_a_d;
         fail_b_q <= fail_b_d;
      end
   end

   // Next-state and sweep datapath.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      a_d      = a_q;
      b_d      = b_q;
      err_d    = err_q;
      fail_a_d = fail_a_q;
      fail_b_d = fail_b_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d  = StWait;
               settle_d = SettleInit;
               a_d      = '0;
               b_d      = '0;
               err_d    = '0;
               fail_a_d = '0;
               fail_b_d = '0;
            end
         end

         StWait: begin
            if (settle_q <= 4'd1) begin
               state_d = StCheck;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end

         StCheck: begin
            if (pair_fail) begin
               err_d = err_q + ErrW'(1);
               // A zero count means this is the first failure of the sweep.
               if (err_q == '0) begin
                  fail_a_d = a_q;
                  fail_b_d = b_q;
               end
            end
            if (!(&b_q)) begin
               b_d      = b_q + WIDTH'(1);
               settle_d = SettleInit;
               state_d  = StWait;
            end else if (!(&a_q)) begin
               b_d      = '0;
               a_d      = a_q + WIDTH'(1);
               settle_d = SettleInit;
               state_d  = StWait;
            end else begin
               state_d = StDone;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and registers; pass can only be high in DONE.
   always_comb begin
      a_out     = a_q;
      b_out     = b_q;
      err_count = err_q;
      fail_a    = fail_a_q;
      fail_b    = fail_b_q;
      busy      = (state_q == StWait) || (state_q == StCheck);
      done      = (state_q == StDone);
      pass      = (state_q == StDone) && (err_q == '0);
   end

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: a behavioural comparator with selectable faults feeds the BIST.
// Expected sweep results are queued when a sweep is started; a monitor pops and checks them
// on each rising edge of done.
module tb_comparator_bist;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned SWEEP_CYCLES = 512;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a_out, b_out;
   logic             eq_in, gt_in, lt_in;
   logic             busy, done, pass;
   logic [2*WIDTH:0] err_count;
   logic [WIDTH-1:0] fail_a, fail_b;

   int fault_mode = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int err;
      int fa;
      int fb;
      int ps;
   } exp_t;

   exp_t sb[$];

   comparator_bist #(.WIDTH(WIDTH), .SETTLE(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a_out     (a_out),
      .b_out     (b_out),
      .eq_in     (eq_in),
      .gt_in     (gt_in),
      .lt_in     (lt_in),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_a    (fail_a),
      .fail_b    (fail_b)
   );

   always #5 clk = ~clk;

   // Comparator under test: 0 good, 1 eq stuck 0, 2 gt/lt swapped, 3 eq+gt at (3,3),
   // 4 all flags stuck 0.
   always_comb begin
      eq_in = (a_out == b_out);
      gt_in = (a_out > b_out);
      lt_in = (a_out < b_out);
      case (fault_mode)
         1: eq_in = 1'b0;
         2: begin
            gt_in = (a_out < b_out);
            lt_in = (a_out > b_out);
         end
         3: if (a_out == 4'd3 && b_out == 4'd3) gt_in = 1'b1;
         4: begin
            eq_in = 1'b0;
            gt_in = 1'b0;
            lt_in = 1'b0;
         end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_exp(input int err, input int fa, input int fb, input int ps);
      exp_t e;
      e.err = err;
      e.fa  = fa;
      e.fb  = fb;
      e.ps  = ps;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_a_out"}, 32'(a_out), 32'd0);
      check({name, "_b_out"}, 32'(b_out), 32'd0);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_done"}, 32'(done), 32'd0);
      check({name, "_pass"}, 32'(pass), 32'd0);
      check({name, "_err_count"}, 32'(err_count), 32'd0);
      check({name, "_fail_a"}, 32'(fail_a), 32'd0);
      check({name, "_fail_b"}, 32'(fail_b), 32'd0);
   endtask

   // Monitor: counts busy cycles and checks each completed sweep against the scoreboard.
   initial begin
      int   busy_cycles;
      bit   done_prev;
      exp_t e;
      busy_cycles = 0;
      done_prev   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cycles = 0;
            done_prev   = 1'b0;
         end else begin
            if (busy) busy_cycles++;
            if (done && !done_prev) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'(done), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("sweep_err_count", 32'(err_count), 32'(e.err));
                  check("sweep_fail_a", 32'(fail_a), 32'(e.fa));
                  check("sweep_fail_b", 32'(fail_b), 32'(e.fb));
                  check("sweep_pass", 32'(pass), 32'(e.ps));
                  check("sweep_busy_cycles", 32'(busy_cycles), 32'(SWEEP_CYCLES));
                  check("sweep_busy_low_at_done", 32'(busy), 32'd0);
               end
               busy_cycles = 0;
            end
            done_prev = done;
         end
      end
   end

   // Global time bound.
   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

   // Stimulus.
   initial begin
      // Reset held with start high: reset must win.
      start = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_start_busy", 32'(busy), 32'd0);

      // Good comparator, with start pulses mid-sweep that must be ignored.
      fault_mode = 0;
      push_exp(0, 0, 0, 1);
      pulse_start();
      check("accept_busy", 32'(busy), 32'd1);
      repeat (9) @(negedge clk);
      pulse_start();
      repeat (288) @(negedge clk);
      pulse_start();
      wait_done("good");

      // eq stuck at 0: fails on the 16 diagonal pairs, first at (0,0).
      fault_mode = 1;
      push_exp(16, 0, 0, 0);
      pulse_start();
      wait_done("eq_stuck0");

      // gt/lt swapped: every off-diagonal pair fails, first at (0,1).
      fault_mode = 2;
      push_exp(240, 0, 1, 0);
      pulse_start();
      wait_done("gt_lt_swap");

      // Zero-hot everywhere: all 256 pairs fail, the largest count.
      fault_mode = 4;
      push_exp(256, 0, 0, 0);
      pulse_start();
      wait_done("zero_hot");

      // Multi-hot only at (3,3).
      fault_mode = 3;
      push_exp(1, 3, 3, 0);
      pulse_start();
      wait_done("multi_hot_33");
      repeat (5) @(negedge clk);
      check("done_held", 32'(done), 32'd1);
      check("done_held_a_out", 32'(a_out), 32'd15);
      check("done_held_b_out", 32'(b_out), 32'd15);

      // Start accepted from DONE clears results and restarts.
      fault_mode = 0;
      push_exp(0, 0, 0, 1);
      pulse_start();
      check("restart_done", 32'(done), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_err_count", 32'(err_count), 32'd0);
      check("restart_fail_a", 32'(fail_a), 32'd0);
      check("restart_fail_b", 32'(fail_b), 32'd0);
      check("restart_a_out", 32'(a_out), 32'd0);
      wait_done("restart");

      // Mid-sweep reset with faults injected, then a fresh good sweep.
      fault_mode = 2;
      pulse_start();
      repeat (99) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("midsweep_reset");
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("no_resume_busy", 32'(busy), 32'd0);
      check("no_resume_a_out", 32'(a_out), 32'd0);
      fault_mode = 0;
      push_exp(0, 0, 0, 1);
      pulse_start();
      wait_done("after_reset");

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
